// File: rtl/npc_halt_pkg.sv
// npc_halt_pkg -- shared definitions for the ebreak halt signaller.
//   EBREAK_INST  : exact encoding that triggers a halt (0x00100073)
//   halt_state_t : controller states IDLE / DRAIN / REQ / HALTED
//   DRAIN_W()    : bit width needed to hold a drain count (minimum 1)
// Optional feature macro used by the block: HALT_PERF_EN.
package npc_halt_pkg;

   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      REQ    = 2'd2,
      HALTED = 2'd3
   } halt_state_t;

   // Smallest width able to represent 0..cycles; never narrower than 1 bit.
   function automatic int DRAIN_W(input int cycles);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if (cycles >= (32'sd1 <<< i)) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/halt_perf_cnt.sv
// halt_perf_cnt -- 64-bit cycle and retired-instruction counters.
// Present only when HALT_PERF_EN is defined.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   freeze_i        : holds both counters (controller has halted)
//   ret_en_i        : one instruction retired and must be counted
//   cycle_cnt_o     : cycles elapsed while not frozen (wraps mod 2^64)
//   instret_cnt_o   : instructions counted (wraps mod 2^64)
`ifdef HALT_PERF_EN
module halt_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        freeze_i,
   input  logic        ret_en_i,
   output logic [63:0] cycle_cnt_o,
   output logic [63:0] instret_cnt_o
);

   logic [63:0] cyc_q, cyc_d;
   logic [63:0] ret_q, ret_d;

   // Next-count computation; freeze overrides both enables.
   always_comb begin
      cyc_d = cyc_q;
      ret_d = ret_q;
      if (freeze_i) begin
         cyc_d = cyc_q;
         ret_d = ret_q;
      end else begin
         cyc_d = cyc_q + 64'd1;
         if (ret_en_i) begin
            ret_d = ret_q + 64'd1;
         end else begin
            ret_d = ret_q;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q <= 64'd0;
         ret_q <= 64'd0;
      end else begin
         cyc_q <= cyc_d;
         ret_q <= ret_d;
      end
   end

   assign cycle_cnt_o   = cyc_q;
   assign instret_cnt_o = ret_q;

endmodule
`endif

// File: rtl/ebreak_halt_ctrl.sv
// ebreak_halt_ctrl -- watches the commit stream for ebreak, latches the
// return code (a0) and trapping PC, freezes the pipeline for DRAIN_CYCLES,
// then offers a one-shot halt report over valid/ready.
// Parameters: XLEN (data/PC width), DRAIN_CYCLES (freeze length, 0 allowed).
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   commit_valid/inst/pc        : retiring instruction
//   a0_value                    : architectural x10 before this instruction
//   stall_o                     : freeze fetch/commit (any state but IDLE)
//   halt_valid / halt_ready     : report handshake
//   halt_code/halt_pc/halt_good : latched report fields
//   halted                      : sticky, handshake done
//   cycle_cnt/instret_cnt       : perf counters, only with HALT_PERF_EN
module ebreak_halt_ctrl
   import npc_halt_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            commit_valid,
   input  logic [31:0]     commit_inst,
   input  logic [XLEN-1:0] commit_pc,
   input  logic [XLEN-1:0] a0_value,
   output logic            stall_o,
   output logic            halt_valid,
   input  logic            halt_ready,
   output logic [XLEN-1:0] halt_code,
   output logic [XLEN-1:0] halt_pc,
   output logic            halt_good,
   output logic            halted
`ifdef HALT_PERF_EN
   ,
   output logic [63:0]     cycle_cnt,
   output logic [63:0]     instret_cnt
`endif
);

   localparam int            CW         = DRAIN_W(DRAIN_CYCLES);
   localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   halt_state_t     state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] code_q, code_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            good_q, good_d;
   logic            hit_s;

   assign hit_s = commit_valid && (commit_inst == EBREAK_INST);

   // State, drain counter and latched report registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         code_q  <= '0;
         pc_q    <= '0;
         good_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         pc_q    <= pc_d;
         good_q  <= good_d;
      end
   end

   // Next-state logic; the report is captured only on an IDLE hit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      pc_d    = pc_q;
      good_d  = good_q;
      case (state_q)
         IDLE: begin
            if (hit_s) begin
               pc_d   = commit_pc;
               code_d = a0_value;
               good_d = (a0_value == '0);
               cnt_d  = DRAIN_LOAD;
               if (DRAIN_CYCLES == 0) begin
                  state_d = REQ;
               end else begin
                  state_d = DRAIN;
               end
            end else begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            // Count of 1 means this is the last frozen cycle.
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = REQ;
            end else begin
               state_d = DRAIN;
            end
         end
         REQ: begin
            // halt_valid is implied in REQ, so ready alone completes it.
            if (halt_ready) begin
               state_d = HALTED;
            end else begin
               state_d = REQ;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode straight from the state register (no input paths).
   always_comb begin
      stall_o    = 1'b0;
      halt_valid = 1'b0;
      halted     = 1'b0;
      case (state_q)
         IDLE: begin
            stall_o = 1'b0;
         end
         DRAIN: begin
            stall_o = 1'b1;
         end
         REQ: begin
            stall_o    = 1'b1;
            halt_valid = 1'b1;
         end
         HALTED: begin
            stall_o = 1'b1;
            halted  = 1'b1;
         end
         default: begin
            stall_o = 1'b0;
         end
      endcase
   end

   assign halt_code = code_q;
   assign halt_pc   = pc_q;
   assign halt_good = good_q;

`ifdef HALT_PERF_EN
   halt_perf_cnt u_perf (
      .clk           (clk),
      .rst_n         (rst_n),
      .freeze_i      (state_q == HALTED),
      .ret_en_i      (commit_valid && (state_q == IDLE)),
      .cycle_cnt_o   (cycle_cnt),
      .instret_cnt_o (instret_cnt)
   );
`endif

endmodule
